mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single block-level data memory between the instruction cache (read-only requester) and the data cache (read/write requester). It sits between both cache controllers and the memory model. It grants one requester at a time using round-robin priority. It registers the granted address and write data, relays the memory busywait handshake, and returns the fetched 32-bit block to the granted cache only.

## Interface
- ADDR_W, 6, block address width (tag+index)
- DATA_W, 32, block width
- TIMEOUT, 255, maximum cycles in ACCESS before abort; counter is 8 bits wide
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; while low, all state is forced to reset values immediately
- ic_read  in  1  instruction-cache block read request
- ic_address  in  ADDR_W  instruction-cache block address
- ic_readdata  out  DATA_W  block returned to instruction cache
- ic_busywait  out  1  stall to instruction cache
- dc_read, dc_write  in  1  data-cache block read / write-back request; never both high
- dc_address  in  ADDR_W  data-cache block address
- dc_writedata  in  DATA_W  write-back block
- dc_readdata  out  DATA_W  block returned to data cache
- dc_busywait  out  1  stall to data cache
- mem_read, mem_write  out  1  memory request strobes
- mem_address  out  ADDR_W  registered granted address
- mem_writedata  out  DATA_W  registered granted write data
- mem_readdata  in  DATA_W  memory block output
- mem_busywait  in  1  memory busy; rises in the same cycle a strobe rises, falls when the access completes
- timeout_err  out  1  sticky abort flag

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - Sample ic_req = ic_read and dc_req = dc_read|dc_write.
  - If exactly one request is present, grant it.
  - If both are present, grant the requester that is not last_grant.
  - On grant: latch owner, op (read/write), address and write data into registers; load last_grant = owner; clear the cycle counter; go to ACCESS.
- ACCESS:
  - Drive mem_read/mem_write from the latched op; drive mem_address/mem_writedata from the registers.
  - Increment the counter each edge.
  - At an edge with mem_busywait == 0: latch mem_readdata into the owner's readdata register (reads only), then go to DONE.
  - Else, if the counter == TIMEOUT-1: set timeout_err, load 0 into the owner's readdata register (reads only), then go to DONE.
- DONE:
  - Strobes are low.
  - Owner busywait is low for exactly this one cycle.
  - Unconditionally go to IDLE at the next edge.
- Busywait (combinational):
  - ic_busywait = ic_read & ~(state==DONE & owner==IC).
  - dc_busywait = (dc_read|dc_write) & ~(state==DONE & owner==DC).
  - A requester that is not granted stays stalled.
- Readdata: the non-owner's readdata register is never modified.
- last_grant: flips only on grant. Reset value = IC, so the first simultaneous contest goes to DC.
- Requests that drop while the owner's access is in ACCESS do not abort it; the memory access completes and the result is discarded by the requester.
- timeout_err is cleared only by reset.

## Timing
- Reset values:
  - state IDLE; mem_read = mem_write = 0; mem_address = 0; mem_writedata = 0.
  - ic_readdata = dc_readdata = 0; timeout_err = 0; last_grant = IC; counter = 0.
  - Busywait outputs follow their equations (= request while in IDLE).
- Reset asserted mid-ACCESS: strobes drop at once and the access is abandoned.
- Grant latency: a request sampled at edge E0 has its strobe high after E0. Completion edge Ec is the first edge with mem_busywait low. The owner sees busywait low in the cycle Ec..Ec+1.
- Minimum transaction: 3 cycles request-to-release (IDLE, ACCESS, DONE) for a 1-cycle memory.
- A requester still asserting after DONE is treated as a new request in IDLE.
- Back-to-back contest: both held high gives alternating grants IC, DC, IC… or DC, IC… with no idle cycle other than the IDLE sampling cycle.
- Strobes and mem_address are glitch-free: both are driven from registers and state only.

## Test plan
- Single IC read:
  - Stimulus: ic_read=1, ic_address=6'h05, memory returns 32'hDEADBEEF after 5 cycles.
  - Required response: mem_read high 5 cycles, mem_address=6'h05, ic_readdata=32'hDEADBEEF, ic_busywait low for 1 cycle, dc_readdata unchanged (0).
- DC write-back:
  - Stimulus: dc_write=1, dc_address=6'h2A, dc_writedata=32'h12345678.
  - Required response: mem_write=1 with mem_writedata=32'h12345678 held stable throughout ACCESS; mem_read stays 0.
- Simultaneous requests after reset:
  - Stimulus: ic_read and dc_read both asserted and held.
  - Required response: grant order is DC, IC, DC; the non-owner's busywait stays high throughout.
- Timeout:
  - Stimulus: memory holds mem_busywait=1 indefinitely.
  - Required response: after 255 ACCESS cycles, timeout_err=1, owner readdata=0, FSM returns to IDLE; timeout_err stays 1 until reset.
- Reset mid-ACCESS:
  - Stimulus: pull reset low 2 cycles into a DC read.
  - Required response: mem_read=0 immediately, all registers at reset values; after release, the next contest grants DC.
- Owner drops request mid-access:
  - Stimulus: IC drops ic_read during ACCESS.
  - Required response: access still completes and ic_readdata updates; the next grant then follows normal round-robin.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing the block memory between I-cache and D-cache
module mem_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_address,
  output logic [DATA_W-1:0] ic_readdata,
  output logic              ic_busywait,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_address,
  input  logic [DATA_W-1:0] dc_writedata,
  output logic [DATA_W-1:0] dc_readdata,
  output logic              dc_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic       OWN_IC       = 1'b0;
  localparam logic       OWN_DC       = 1'b1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner;
  logic       last_grant;
  logic [7:0] count;
  logic       ic_req;
  logic       dc_req;
  logic       grant_dc;

  assign ic_req = ic_read;
  assign dc_req = dc_read | dc_write;

  // DC wins when alone, or in a contest when IC held the previous grant
  assign grant_dc = dc_req & (~ic_req | (last_grant == OWN_IC));

  assign ic_busywait = ic_req & ~((state == DONE) & (owner == OWN_IC));
  assign dc_busywait = dc_req & ~((state == DONE) & (owner == OWN_DC));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= OWN_IC;
      last_grant    <= OWN_IC;
      count         <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      ic_readdata   <= '0;
      dc_readdata   <= '0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_req | dc_req) begin
            owner         <= grant_dc;
            last_grant    <= grant_dc;
            count         <= '0;
            mem_address   <= grant_dc ? dc_address : ic_address;
            mem_writedata <= grant_dc ? dc_writedata : '0;
            mem_read      <= grant_dc ? dc_read : 1'b1;
            mem_write     <= grant_dc & dc_write;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          count <= count + 8'd1;
          // the registered write strobe doubles as the latched operation
          if (!mem_busywait) begin
            if (!mem_write) begin
              if (owner == OWN_DC) dc_readdata <= mem_readdata;
              else                 ic_readdata <= mem_readdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else if (count == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            if (!mem_write) begin
              if (owner == OWN_DC) dc_readdata <= '0;
              else                 ic_readdata <= '0;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_read, dc_read, dc_write;
  logic [5:0]  ic_address, dc_address, mem_address;
  logic [31:0] dc_writedata, ic_readdata, dc_readdata, mem_writedata, mem_readdata;
  logic        ic_busywait, dc_busywait, mem_read, mem_write, mem_busywait, timeout_err;

  int checks = 0;
  int failures = 0;

  // memory model: busywait rises with the strobe and drops in the lat-th strobe cycle
  int          lat = 1;
  bit          hold = 0;
  int          mcnt = 0;
  logic [31:0] rval = '0;

  int          scyc, ticks, stall_bad, unstable, rd_cyc, wr_cyc;
  bit          done;
  logic [5:0]  first_addr;
  logic [31:0] first_wd;
  logic        first_rd;

  always #5 clk = ~clk;

  always @(posedge clk) mcnt <= (mem_read | mem_write) ? mcnt + 1 : 0;
  assign mem_busywait = (mem_read | mem_write) && (hold || (mcnt < lat - 1));
  assign mem_readdata = rval;

  mem_arbiter #(.ADDR_W(6), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .ic_read(ic_read), .ic_address(ic_address), .ic_readdata(ic_readdata), .ic_busywait(ic_busywait),
    .dc_read(dc_read), .dc_write(dc_write), .dc_address(dc_address), .dc_writedata(dc_writedata),
    .dc_readdata(dc_readdata), .dc_busywait(dc_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .timeout_err(timeout_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance until a strobe burst has been seen and ended; returns in the DONE cycle
  task automatic run_access;
    bit seen;
    seen = 0; scyc = 0; ticks = 0; done = 0; stall_bad = 0; unstable = 0; rd_cyc = 0; wr_cyc = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      tick();
      ticks++;
      if (mem_read | mem_write) begin
        if (!seen) begin
          first_addr = mem_address; first_wd = mem_writedata; first_rd = mem_read;
        end else if (mem_address !== first_addr || mem_writedata !== first_wd || mem_read !== first_rd) begin
          unstable++;
        end
        seen = 1;
        scyc++;
        if (mem_read) rd_cyc++;
        if (mem_write) wr_cyc++;
        if ((ic_read && !ic_busywait) || ((dc_read | dc_write) && !dc_busywait)) stall_bad++;
      end else if (seen) begin
        done = 1;
      end
    end
  endtask

  initial begin
    reset = 1'b0; ic_read = 1'b1; dc_read = 1'b0; dc_write = 1'b0;
    ic_address = '0; dc_address = '0; dc_writedata = '0;
    tick();
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_address", mem_address, 6'h00);
    check("rst_mem_writedata", mem_writedata, 32'h0);
    check("rst_ic_readdata", ic_readdata, 32'h0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_ic_busywait_follows_req", ic_busywait, 1'b1);
    ic_read = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_ic_busywait_no_req", ic_busywait, 1'b0);

    // single IC read, 5-cycle memory
    ic_read = 1'b1; ic_address = 6'h05; lat = 5; rval = 32'hDEADBEEF;
    run_access();
    check("ic1_done", done, 1'b1);
    check("ic1_strobe_cycles", scyc, 5);
    check("ic1_read_cycles", rd_cyc, 5);
    check("ic1_address", first_addr, 6'h05);
    check("ic1_busywait_done", ic_busywait, 1'b0);
    check("ic1_readdata", ic_readdata, 32'hDEADBEEF);
    check("ic1_dc_readdata", dc_readdata, 32'h0);
    tick();
    check("ic1_busywait_after_done", ic_busywait, 1'b1);
    ic_read = 1'b0;
    tick();
    check("ic1_no_regrant", mem_read, 1'b0);

    // DC write-back
    dc_write = 1'b1; dc_address = 6'h2A; dc_writedata = 32'h12345678; lat = 3;
    run_access();
    check("dcw_done", done, 1'b1);
    check("dcw_write_cycles", wr_cyc, 3);
    check("dcw_read_cycles", rd_cyc, 0);
    check("dcw_address", first_addr, 6'h2A);
    check("dcw_writedata", first_wd, 32'h12345678);
    check("dcw_unstable", unstable, 0);
    check("dcw_busywait_done", dc_busywait, 1'b0);
    check("dcw_dc_readdata", dc_readdata, 32'h0);
    dc_write = 1'b0; dc_writedata = '0;
    tick();

    // simultaneous contest after reset: DC, IC, DC
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ic_read = 1'b1; ic_address = 6'h01; dc_read = 1'b1; dc_address = 6'h02; lat = 2; rval = 32'hA1A1A1A1;
    run_access();
    check("c1_addr", first_addr, 6'h02);
    check("c1_ic_busywait", ic_busywait, 1'b1);
    check("c1_dc_busywait", dc_busywait, 1'b0);
    check("c1_dc_readdata", dc_readdata, 32'hA1A1A1A1);
    check("c1_ic_readdata", ic_readdata, 32'h0);
    check("c1_stall", stall_bad, 0);
    rval = 32'hB2B2B2B2;
    run_access();
    check("c2_addr", first_addr, 6'h01);
    check("c2_ticks", ticks, 4);
    check("c2_ic_busywait", ic_busywait, 1'b0);
    check("c2_dc_busywait", dc_busywait, 1'b1);
    check("c2_ic_readdata", ic_readdata, 32'hB2B2B2B2);
    check("c2_dc_readdata", dc_readdata, 32'hA1A1A1A1);
    check("c2_stall", stall_bad, 0);
    rval = 32'hC3C3C3C3;
    run_access();
    check("c3_addr", first_addr, 6'h02);
    check("c3_ticks", ticks, 4);
    check("c3_dc_busywait", dc_busywait, 1'b0);
    check("c3_ic_busywait", ic_busywait, 1'b1);
    check("c3_dc_readdata", dc_readdata, 32'hC3C3C3C3);
    check("c3_ic_readdata", ic_readdata, 32'hB2B2B2B2);
    check("c3_stall", stall_bad, 0);
    ic_read = 1'b0; dc_read = 1'b0;
    tick();

    // timeout on a stuck memory
    ic_read = 1'b1; ic_address = 6'h03; hold = 1;
    run_access();
    check("to_done", done, 1'b1);
    check("to_access_cycles", scyc, 255);
    check("to_err", timeout_err, 1'b1);
    check("to_ic_readdata", ic_readdata, 32'h0);
    check("to_dc_readdata", dc_readdata, 32'hC3C3C3C3);
    check("to_ic_busywait", ic_busywait, 1'b0);
    ic_read = 1'b0; hold = 0;
    tick();
    check("to_back_idle", mem_read, 1'b0);
    dc_read = 1'b1; dc_address = 6'h04; lat = 1; rval = 32'h0F0F0F0F;
    run_access();
    check("to_next_cycles", scyc, 1);
    check("to_next_dc_readdata", dc_readdata, 32'h0F0F0F0F);
    check("to_err_sticky", timeout_err, 1'b1);
    dc_read = 1'b0;
    tick();

    // reset two cycles into a DC read
    dc_read = 1'b1; dc_address = 6'h06; lat = 10;
    tick();
    tick();
    check("rm_in_access", mem_read, 1'b1);
    reset = 1'b0;
    #1;
    check("rm_mem_read", mem_read, 1'b0);
    check("rm_mem_address", mem_address, 6'h00);
    check("rm_dc_readdata", dc_readdata, 32'h0);
    check("rm_ic_readdata", ic_readdata, 32'h0);
    check("rm_timeout_err", timeout_err, 1'b0);
    check("rm_dc_busywait", dc_busywait, 1'b1);
    ic_read = 1'b1; ic_address = 6'h11;
    tick();
    reset = 1'b1; lat = 2; rval = 32'h00005A5A;
    run_access();
    check("rm_first_grant_addr", first_addr, 6'h06);
    check("rm_dc_busywait_done", dc_busywait, 1'b0);
    check("rm_ic_busywait_done", ic_busywait, 1'b1);
    check("rm_dc_readdata_new", dc_readdata, 32'h00005A5A);

    // IC owner drops its request during ACCESS
    lat = 4; rval = 32'h00000077;
    tick();
    tick();
    check("drop_granted", mem_read, 1'b1);
    check("drop_addr", mem_address, 6'h11);
    ic_read = 1'b0;
    run_access();
    check("drop_done", done, 1'b1);
    check("drop_remaining", scyc, 3);
    check("drop_ic_readdata", ic_readdata, 32'h00000077);
    check("drop_dc_busywait", dc_busywait, 1'b1);
    ic_read = 1'b1; lat = 2; rval = 32'h00000088;
    run_access();
    check("drop_next_addr", first_addr, 6'h06);
    check("drop_next_dc_busywait", dc_busywait, 1'b0);
    check("drop_next_dc_readdata", dc_readdata, 32'h00000088);
    check("drop_next_ic_readdata", ic_readdata, 32'h00000077);
    ic_read = 1'b0; dc_read = 1'b0;
    tick();
    check("end_timeout_err", timeout_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
